// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: multi-cycle fetch/decode/execute control for the
// accumulator processor. The state register, latched opcode/z and the
// retired-instruction counter are registered. All control outputs are decoded
// combinationally from the current state, the latched opcode/z, z_flag and
// mem_ready, so the decoders, the ALU and the memory handshake see them in the
// same cycle.
module cpu_control_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             z_flag,
    input  logic             mem_ready,
    output logic [2:0]       write_sel,
    output logic             write_en,
    output logic [2:0]       inc_sel,
    output logic             inc_en,
    output logic [2:0]       bus_sel,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F1     = 4'd1,
        S_F2     = 4'd2,
        S_F3     = 4'd3,
        S_DECODE = 4'd4,
        S_EX1    = 4'd5,
        S_EX2    = 4'd6,
        S_EX3    = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    // Register codes shared by write_sel and inc_sel
    localparam logic [2:0] R_AC   = 3'd0;
    localparam logic [2:0] R_AR   = 3'd1;
    localparam logic [2:0] R_DR   = 3'd2;
    localparam logic [2:0] R_IR   = 3'd3;
    localparam logic [2:0] R_PC   = 3'd4;
    localparam logic [2:0] R_NONE = 3'd7;

    // Bus source codes
    localparam logic [2:0] B_NONE = 3'd0;
    localparam logic [2:0] B_PC   = 3'd2;
    localparam logic [2:0] B_DR   = 3'd3;
    localparam logic [2:0] B_AC   = 3'd4;
    localparam logic [2:0] B_IR   = 3'd5;
    localparam logic [2:0] B_MEM  = 3'd7;

    // ALU operations
    localparam logic [1:0] A_PASS = 2'd0;
    localparam logic [1:0] A_ADD  = 2'd1;
    localparam logic [1:0] A_SUB  = 2'd2;
    localparam logic [1:0] A_CLR  = 2'd3;

    // Opcodes
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_JZ    = 4'h6;
    localparam logic [3:0] OP_INAC  = 4'h7;
    localparam logic [3:0] OP_CLAC  = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State, latched opcode/z and retired counter; synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 4'd0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and control-output decode; everything defaults to idle values
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        z_d        = z_q;
        write_sel  = R_NONE;
        write_en   = 1'b0;
        inc_sel    = R_NONE;
        inc_en     = 1'b0;
        bus_sel    = B_NONE;
        alu_op     = A_PASS;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_F1;
                else       state_d = S_IDLE;
            end
            S_F1: begin
                bus_sel   = B_PC;
                write_sel = R_AR;
                write_en  = 1'b1;
                state_d   = S_F2;
            end
            S_F2: begin
                // Strobe, bus and destinations hold steady while memory waits
                mem_read  = 1'b1;
                bus_sel   = B_MEM;
                write_sel = R_DR;
                write_en  = mem_ready;
                inc_sel   = R_PC;
                inc_en    = mem_ready;
                if (mem_ready) state_d = S_F3;
                else           state_d = S_F2;
            end
            S_F3: begin
                bus_sel   = B_DR;
                write_sel = R_IR;
                write_en  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                op_d = opcode;
                if (opcode == OP_JZ) z_d = z_flag;
                else                 z_d = z_q;
                case (opcode)
                    OP_NOP: begin
                        instr_done = 1'b1;
                        state_d    = S_F1;
                    end
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_JMP,
                    OP_JZ, OP_INAC, OP_CLAC, OP_HALT: begin
                        state_d = S_EX1;
                    end
                    default: begin
                        // Unassigned opcode: flag it and retire as a NOP
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_F1;
                    end
                endcase
            end
            S_EX1: begin
                case (op_q)
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB: begin
                        bus_sel   = B_IR;
                        write_sel = R_AR;
                        write_en  = 1'b1;
                        state_d   = S_EX2;
                    end
                    OP_JMP: begin
                        bus_sel    = B_IR;
                        write_sel  = R_PC;
                        write_en   = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_F1;
                    end
                    OP_JZ: begin
                        if (z_q) begin
                            bus_sel   = B_IR;
                            write_sel = R_PC;
                            write_en  = 1'b1;
                        end else begin
                            bus_sel   = B_NONE;
                        end
                        instr_done = 1'b1;
                        state_d    = S_F1;
                    end
                    OP_INAC: begin
                        inc_sel    = R_AC;
                        inc_en     = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_F1;
                    end
                    OP_CLAC: begin
                        write_sel  = R_AC;
                        write_en   = 1'b1;
                        alu_op     = A_CLR;
                        instr_done = 1'b1;
                        state_d    = S_F1;
                    end
                    OP_HALT: begin
                        instr_done = 1'b1;
                        state_d    = S_HALT;
                    end
                    default: begin
                        instr_done = 1'b1;
                        state_d    = S_F1;
                    end
                endcase
            end
            S_EX2: begin
                case (op_q)
                    OP_LOAD, OP_ADD, OP_SUB: begin
                        mem_read  = 1'b1;
                        bus_sel   = B_MEM;
                        write_sel = R_DR;
                        write_en  = mem_ready;
                        if (mem_ready) state_d = S_EX3;
                        else           state_d = S_EX2;
                    end
                    OP_STORE: begin
                        bus_sel   = B_AC;
                        write_sel = R_DR;
                        write_en  = 1'b1;
                        state_d   = S_EX3;
                    end
                    default: state_d = S_F1;
                endcase
            end
            S_EX3: begin
                case (op_q)
                    OP_LOAD, OP_ADD, OP_SUB: begin
                        bus_sel    = B_DR;
                        write_sel  = R_AC;
                        write_en   = 1'b1;
                        if (op_q == OP_ADD)      alu_op = A_ADD;
                        else if (op_q == OP_SUB) alu_op = A_SUB;
                        else                     alu_op = A_PASS;
                        instr_done = 1'b1;
                        state_d    = S_F1;
                    end
                    OP_STORE: begin
                        mem_write  = 1'b1;
                        bus_sel    = B_DR;
                        instr_done = mem_ready;
                        if (mem_ready) state_d = S_F1;
                        else           state_d = S_EX3;
                    end
                    default: state_d = S_F1;
                endcase
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Retired count advances on the edge that closes an instruction
        if (instr_done) cnt_d = cnt_q + CNT_W'(1);
        else            cnt_d = cnt_q;
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = (state_q == S_HALT);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Testbench for cpu_control_sequencer. Each instruction is expanded by the
// bench into its expected per-cycle control trace (micro-steps with memory
// waits), which is then replayed against the DUT. A vector table checks
// instruction lengths; random instructions, HALT and a reset abort follow.
module tb_cpu_control_sequencer;

    localparam int CW = 4;   // small counter so wrap-around is exercised

    logic          clk = 1'b0;
    logic          reset, start, z_flag, mem_ready;
    logic [3:0]    opcode;
    logic [2:0]    write_sel, inc_sel, bus_sel;
    logic [1:0]    alu_op;
    logic          write_en, inc_en, mem_read, mem_write;
    logic          busy, halted, illegal, instr_done;
    logic [CW-1:0] instr_count;

    cpu_control_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .z_flag(z_flag), .mem_ready(mem_ready),
        .write_sel(write_sel), .write_en(write_en),
        .inc_sel(inc_sel), .inc_en(inc_en), .bus_sel(bus_sel),
        .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
        .busy(busy), .halted(halted), .illegal(illegal),
        .instr_done(instr_done), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Observed control bundle
    logic [18:0] obs;
    assign obs = {write_sel, write_en, inc_sel, inc_en, bus_sel, alu_op,
                  mem_read, mem_write, busy, halted, illegal, instr_done};

    localparam logic [2:0] AC = 3'd0, AR = 3'd1, DR = 3'd2, IR = 3'd3,
                           PC = 3'd4, NONE = 3'd7;
    localparam logic [2:0] B_NONE = 3'd0, B_PC = 3'd2, B_DR = 3'd3,
                           B_AC = 3'd4, B_IR = 3'd5, B_MEM = 3'd7;
    localparam logic [18:0] RST_V  = {3'd7, 1'b0, 3'd7, 1'b0, 3'd0, 2'd0,
                                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [18:0] HALT_V = {3'd7, 1'b0, 3'd7, 1'b0, 3'd0, 2'd0,
                                      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    typedef struct {
        logic        rdy;
        logic        dec;
        logic [18:0] exp;
    } cyc_t;

    typedef struct {
        logic [3:0] op;
        logic       z;
        int         wf2;
        int         wex;
        int         cycles;
    } vec_t;

    cyc_t          q[$];
    vec_t          vecs[11];
    int            checks = 0;
    int            failures = 0;
    logic [CW-1:0] exp_cnt;
    int            cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected bundle for a busy cycle
    function automatic logic [18:0] o(input logic [2:0] ws, input logic we,
                                      input logic [2:0] is, input logic ie,
                                      input logic [2:0] bs, input logic [1:0] alu,
                                      input logic mr, input logic mw,
                                      input logic ill, input logic dn);
        return {ws, we, is, ie, bs, alu, mr, mw, 1'b1, 1'b0, ill, dn};
    endfunction

    task automatic add(input logic rdy, input logic dec, input logic [18:0] e);
        cyc_t c;
        c.rdy = rdy; c.dec = dec; c.exp = e;
        q.push_back(c);
    endtask

    // Memory step: w cycles with mem_ready low, then the completing cycle
    task automatic add_mem(input int w, input logic [18:0] wait_v, input logic [18:0] go_v);
        repeat (w) add(1'b0, 1'b0, wait_v);
        add(1'b1, 1'b0, go_v);
    endtask

    // Expand one instruction into its expected per-cycle trace
    task automatic build(input logic [3:0] op, input logic z, input int wf2, input int wex);
        logic ill, nop;
        logic [1:0] a;
        q.delete();
        ill = (op >= 4'h9) && (op <= 4'hE);
        nop = (op == 4'h0) || ill;
        add(1'($urandom), 1'b0, o(AR, 1'b1, NONE, 1'b0, B_PC, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        add_mem(wf2, o(DR, 1'b0, PC, 1'b0, B_MEM, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0),
                     o(DR, 1'b1, PC, 1'b1, B_MEM, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        add(1'($urandom), 1'b0, o(IR, 1'b1, NONE, 1'b0, B_DR, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(1'($urandom), 1'b1, o(NONE, 1'b0, NONE, 1'b0, B_NONE, 2'd0, 1'b0, 1'b0, ill, nop));
        if (!nop) begin
            case (op)
                4'h1, 4'h3, 4'h4: begin
                    a = (op == 4'h1) ? 2'd0 : ((op == 4'h3) ? 2'd1 : 2'd2);
                    add(1'($urandom), 1'b0, o(AR, 1'b1, NONE, 1'b0, B_IR, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
                    add_mem(wex, o(DR, 1'b0, NONE, 1'b0, B_MEM, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0),
                                 o(DR, 1'b1, NONE, 1'b0, B_MEM, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
                    add(1'($urandom), 1'b0, o(AC, 1'b1, NONE, 1'b0, B_DR, a, 1'b0, 1'b0, 1'b0, 1'b1));
                end
                4'h2: begin
                    add(1'($urandom), 1'b0, o(AR, 1'b1, NONE, 1'b0, B_IR, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
                    add(1'($urandom), 1'b0, o(DR, 1'b1, NONE, 1'b0, B_AC, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
                    add_mem(wex, o(NONE, 1'b0, NONE, 1'b0, B_DR, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0),
                                 o(NONE, 1'b0, NONE, 1'b0, B_DR, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1));
                end
                4'h5: add(1'($urandom), 1'b0, o(PC, 1'b1, NONE, 1'b0, B_IR, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
                4'h6: begin
                    if (z) add(1'($urandom), 1'b0, o(PC, 1'b1, NONE, 1'b0, B_IR, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
                    else   add(1'($urandom), 1'b0, o(NONE, 1'b0, NONE, 1'b0, B_NONE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
                end
                4'h7: add(1'($urandom), 1'b0, o(NONE, 1'b0, AC, 1'b1, B_NONE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
                4'h8: add(1'($urandom), 1'b0, o(AC, 1'b1, NONE, 1'b0, B_NONE, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1));
                default: add(1'($urandom), 1'b0, o(NONE, 1'b0, NONE, 1'b0, B_NONE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
            endcase
        end
    endtask

    // Replay up to 'limit' cycles of an instruction; starts and ends at posedge+1
    task automatic run(input string tag, input logic [3:0] op, input logic z,
                       input int wf2, input int wex, input int limit, output int ncyc);
        build(op, z, wf2, wex);
        ncyc = 0;
        for (int i = 0; i < q.size() && i < limit; i++) begin
            mem_ready = q[i].rdy;
            start     = 1'($urandom);
            opcode    = q[i].dec ? op : 4'($urandom);
            z_flag    = q[i].dec ? z : 1'($urandom);
            @(negedge clk);
            chk({tag, "_trace"}, 32'(obs), 32'(q[i].exp));
            if (instr_done && ncyc == 0) ncyc = i + 1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (limit >= q.size()) begin
            exp_cnt = exp_cnt + 1'b1;
            chk({tag, "_count"}, 32'(instr_count), 32'(exp_cnt));
        end
    endtask

    initial begin
        vecs[0]  = '{op: 4'h0, z: 1'b0, wf2: 0, wex: 0, cycles: 4};
        vecs[1]  = '{op: 4'h1, z: 1'b0, wf2: 0, wex: 0, cycles: 7};
        vecs[2]  = '{op: 4'h2, z: 1'b0, wf2: 0, wex: 3, cycles: 10};
        vecs[3]  = '{op: 4'h6, z: 1'b1, wf2: 0, wex: 0, cycles: 5};
        vecs[4]  = '{op: 4'h6, z: 1'b0, wf2: 0, wex: 0, cycles: 5};
        vecs[5]  = '{op: 4'hB, z: 1'b0, wf2: 0, wex: 0, cycles: 4};
        vecs[6]  = '{op: 4'h5, z: 1'b0, wf2: 0, wex: 0, cycles: 5};
        vecs[7]  = '{op: 4'h7, z: 1'b0, wf2: 0, wex: 0, cycles: 5};
        vecs[8]  = '{op: 4'h8, z: 1'b0, wf2: 0, wex: 0, cycles: 5};
        vecs[9]  = '{op: 4'h3, z: 1'b0, wf2: 2, wex: 1, cycles: 10};
        vecs[10] = '{op: 4'h4, z: 1'b0, wf2: 1, wex: 0, cycles: 8};

        reset = 1'b1; start = 1'b0; opcode = 4'd0; z_flag = 1'b0; mem_ready = 1'b0;
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            chk("reset_outputs", 32'(obs), 32'(RST_V));
            chk("reset_count", 32'(instr_count), 32'd0);
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(negedge clk);
        chk("idle_with_start", 32'(obs), 32'(RST_V));
        @(posedge clk); #1;
        start = 1'b0;

        // Vector table: trace plus total length of each instruction
        for (int v = 0; v < 11; v++) begin
            run("vec", vecs[v].op, vecs[v].z, vecs[v].wf2, vecs[v].wex, 1000, cyc);
            chk("vec_cycles", 32'(cyc), 32'(vecs[v].cycles));
        end

        // Random instruction stream (HALT excluded)
        for (int n = 0; n < 40; n++) begin
            run("rand", 4'($urandom_range(14, 0)), 1'($urandom),
                $urandom_range(3, 0), $urandom_range(3, 0), 1000, cyc);
        end

        // HALT: retires in 5 cycles, then parks ignoring start
        run("halt", 4'hF, 1'b0, 0, 0, 1000, cyc);
        chk("halt_cycles", 32'(cyc), 32'd5);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            mem_ready = 1'($urandom);
            @(negedge clk);
            chk("halt_park", 32'(obs), 32'(HALT_V));
            @(posedge clk); #1;
        end
        start = 1'b0;

        // Leave HALT by reset, then abort a LOAD during its EX2 wait
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = '0;
        @(negedge clk);
        chk("post_halt_reset", 32'(obs), 32'(RST_V));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run("abort", 4'h1, 1'b0, 0, 5, 6, cyc);
        reset = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("abort_wait_read", 32'(mem_read), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("abort_outputs", 32'(obs), 32'(RST_V));
        chk("abort_count", 32'(instr_count), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_stays_idle", 32'(obs), 32'(RST_V));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_control_sequencer.md
# cpu_control_sequencer

Multi-cycle control sequencer for the accumulator processor. Steps a fetch/decode/execute state machine and produces, every cycle, the destination code for the register write-enable decoder, the increment-select code, the bus source select, the ALU op and the memory read/write strobes. Its outputs connect directly to the register-select decoders, the ALU and the memory handshake.

## Interface
Parameters:
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  leave IDLE; sampled only in IDLE.
- `opcode`  in  4  IR[15:12], sampled in DECODE.
- `z_flag`  in  1  AC==0, sampled in DECODE.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `write_sel`  out  3  write destination: 000 AC, 001 AR, 010 DR, 011 IR, 100 PC, 101 R, 110 TR, 111 none.
- `write_en`  out  1  commits `write_sel` this edge.
- `inc_sel`  out  3  increment target, same encoding as `write_sel`.
- `inc_en`  out  1  commits `inc_sel`.
- `bus_sel`  out  3  000 none, 001 AR, 010 PC, 011 DR, 100 AC, 101 IR(addr), 110 TR, 111 MEM.
- `alu_op`  out  2  00 PASS(DR), 01 ADD, 10 SUB, 11 CLR; meaningful only when writing AC.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `busy`  out  1  state is neither IDLE nor HALT.
- `halted`  out  1  state is HALT.
- `illegal`  out  1  one-cycle pulse in DECODE for an unassigned opcode.
- `instr_done`  out  1  one-cycle pulse in the last cycle of each instruction.
- `instr_count`  out  CNT_W  retired instructions; wraps.

## Operation
- States: IDLE, F1, F2, F3, DECODE, EX1, EX2, EX3, HALT.
- Outputs decode combinationally from state, latched opcode, `z_flag` and `mem_ready`. In every state not listed below: `write_sel`=111, all enables and strobes 0, `bus_sel`=000, `alu_op`=00.
- IDLE: if `start`, go to F1.
- F1: AR<-PC (bus PC, write AR).
- F2: `mem_read`=1, bus MEM, write DR with `write_en`=`mem_ready`, `inc_en`=`mem_ready` on PC. Stay in F2 until `mem_ready`.
- F3: IR<-DR.
- DECODE: latch `opcode` into an internal register.
  - For JZ, also latch `z_flag`.
  - For an unassigned opcode (9–E), pulse `illegal` and execute as NOP.
- Opcodes (0–8 and F assigned):
  - 0 NOP: DECODE is the last cycle.
  - 1 LOAD: EX1 AR<-IR addr; EX2 DR<-MEM, waits on `mem_ready`; EX3 AC<-DR (PASS).
  - 2 STORE: EX1 AR<-IR addr; EX2 DR<-AC; EX3 `mem_write`=1, bus DR, waits on `mem_ready`.
  - 3 ADD / 4 SUB: same as LOAD, except EX3 `alu_op` is ADD / SUB.
  - 5 JMP: EX1 PC<-IR addr.
  - 6 JZ: EX1 PC<-IR addr if latched z is 1; otherwise EX1 asserts no writes.
  - 7 INAC: EX1 `inc_en` on AC.
  - 8 CLAC: EX1 AC<-CLR.
  - F HALT: go to HALT and stay there until `reset`; `start` is ignored.
- After an instruction's last cycle, go to F1 (HALT excepted).
- `instr_done` asserts in that last cycle; `instr_count` increments at the same edge. HALT counts as retired.
- No state ever asserts `write_en` and `inc_en` on the same target.

## Timing
- Reset: state IDLE, `instr_count`=0, latched opcode and z cleared.
  - All outputs at reset: `write_sel`=111, `inc_sel`=111, `bus_sel`=000, `alu_op`=00, every 1-bit output 0.
- Reset asserted mid-instruction (including during a memory wait) aborts at the next edge. Strobes drop in the following cycle; no partial write is recorded by the sequencer.
- With zero-wait memory (`mem_ready` high on the strobe's first cycle), cycles from F1 to the last cycle are:
  - NOP or illegal: 4.
  - JMP, JZ, INAC, CLAC, HALT: 5.
  - LOAD, STORE, ADD, SUB: 7.
- Each extra low cycle of `mem_ready` adds 1 cycle to F2, EX2 or EX3, as applicable.
- Wait handshake: the strobe, `bus_sel` and `write_sel` stay constant throughout the wait. `write_en`/`inc_en` assert only in the `mem_ready` cycle.
- `start` asserted while not in IDLE has no effect.
- `mem_ready` outside a memory state is ignored.
- `instr_count` wraps from all-ones to 0.

## Test plan
- Reset, then hold idle 3 cycles -> all outputs at reset values, `busy`=0; `start` pulse -> F1 next cycle with `bus_sel`=010, `write_sel`=001, `write_en`=1.
- Program NOP, then LOAD, with zero-wait memory -> `instr_done` after 4 cycles and then after 7 more; LOAD EX3 shows `write_sel`=000, `alu_op`=00; `instr_count`=2.
- STORE with `mem_ready` held low 3 cycles in EX3 -> `mem_write`=1 and `bus_sel`=011 for 4 cycles; instruction totals 10 cycles.
- JZ run twice, with `z_flag`=1 and then 0 at DECODE -> first: EX1 `write_sel`=100, `write_en`=1; second: `write_sel`=111, `write_en`=0; both take 5 cycles.
- Opcode 0xB -> `illegal` pulses once in DECODE; behaves as NOP, 4 cycles; `instr_count` increments.
- HALT -> `halted`=1 and `busy`=0 from the next cycle; `start` is ignored. Then `reset` asserted during a LOAD EX2 wait -> IDLE and all outputs at reset values the following cycle.
